// File: rtl/mastermind_pkg.sv
// mastermind_pkg: scorer state encoding and per-position feedback codes
package mastermind_pkg;
  typedef enum logic [1:0] {IDLE, EXACT, PARTIAL, DONE} state_t;
  localparam logic [1:0] FB_NONE    = 2'b00;
  localparam logic [1:0] FB_PARTIAL = 2'b01;
  localparam logic [1:0] FB_EXACT   = 2'b11;
endpackage

// File: rtl/guess_scorer_if.sv
// guess_scorer_if: operand, control and result bundle between a game controller and the scorer
interface guess_scorer_if #(parameter int N_POS = 4, parameter int SYM_W = 3);
  localparam int CW = $clog2(N_POS + 1);
  logic                   start;
  logic [N_POS*SYM_W-1:0] guess_val;
  logic [N_POS*SYM_W-1:0] secret_val;
  logic                   mode;
  logic                   game_over;
  logic [2*N_POS-1:0]     leds;
  logic                   busy;
  logic                   done;
  logic [CW-1:0]          exact_cnt;
  logic [CW-1:0]          partial_cnt;
  logic                   win;
  modport master (output start, guess_val, secret_val, mode, game_over,
                  input leds, busy, done, exact_cnt, partial_cnt, win);
  modport slave  (input start, guess_val, secret_val, mode, game_over,
                  output leds, busy, done, exact_cnt, partial_cnt, win);
endinterface

// File: rtl/blink_timer.sv
// blink_timer: free-running blink phase while enabled, parked on the lit phase otherwise
module blink_timer #(parameter int BLINK_DIV = 4) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic blink_state
);
  localparam int TW = $clog2(BLINK_DIV + 1);
  logic [TW-1:0] timer;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      timer       <= '0;
      blink_state <= 1'b0;
    end else if (!enable) begin
      timer       <= '0;
      blink_state <= 1'b1;
    end else if (timer == TW'(BLINK_DIV)) begin
      timer       <= '0;
      blink_state <= ~blink_state;
    end else begin
      timer <= timer + 1'b1;
    end
endmodule

// File: rtl/guess_scorer.sv
// guess_scorer: sequential Mastermind scoring (exact pass, then one partial lookup per cycle) with LED display
module guess_scorer import mastermind_pkg::*; #(
  parameter int N_POS     = 4,
  parameter int SYM_W     = 3,
  parameter int BLINK_DIV = 4
) (
  input logic           clk,
  input logic           reset,
  guess_scorer_if.slave bus
);
  localparam int CW = $clog2(N_POS + 1);
  localparam int IW = $clog2(N_POS);
  state_t                 state, nxt;
  logic [N_POS*SYM_W-1:0] g_q, s_q;
  logic                   mode_q, res_mode, load, hit, blink;
  logic [N_POS-1:0]       ex, ex_c, pa, used;
  logic [IW-1:0]          idx, hj;
  logic [2*N_POS-1:0]     fb, fb_c, summ;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= nxt;
  always_comb
    nxt = state == IDLE    ? (bus.start ? EXACT : IDLE) :
          state == EXACT   ? PARTIAL :
          state == PARTIAL ? (idx == '0 ? DONE : PARTIAL) : IDLE;
  always_comb begin
    bus.busy = state != IDLE;
    load     = state == DONE;
  end
  always_comb begin
    ex_c = '0;
    for (int i = 0; i < N_POS; i++)
      ex_c[i] = g_q[i*SYM_W +: SYM_W] == s_q[i*SYM_W +: SYM_W];
  end
  // ascending scan so the last hit is the highest unused matching secret index
  always_comb begin
    hit = 1'b0;
    hj  = '0;
    for (int j = 0; j < N_POS; j++)
      if (!used[j] && s_q[j*SYM_W +: SYM_W] == g_q[idx*SYM_W +: SYM_W]) begin
        hit = 1'b1;
        hj  = IW'(j);
      end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      g_q    <= '0;
      s_q    <= '0;
      mode_q <= 1'b0;
      ex     <= '0;
      pa     <= '0;
      used   <= '0;
      idx    <= '0;
    end else if (state == IDLE && bus.start) begin
      g_q    <= bus.guess_val;
      s_q    <= bus.secret_val;
      mode_q <= bus.mode;
    end else if (state == EXACT) begin
      ex   <= ex_c;
      used <= ex_c;
      pa   <= '0;
      idx  <= IW'(N_POS - 1);
    end else if (state == PARTIAL) begin
      if (!ex[idx] && hit) begin
        pa[idx]  <= 1'b1;
        used[hj] <= 1'b1;
      end
      idx <= idx - 1'b1;
    end
  always_comb begin
    fb_c = '0;
    for (int i = 0; i < N_POS; i++)
      fb_c[2*i +: 2] = ex[i] ? FB_EXACT : pa[i] ? FB_PARTIAL : FB_NONE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fb              <= '0;
      res_mode        <= 1'b0;
      bus.done        <= 1'b0;
      bus.exact_cnt   <= '0;
      bus.partial_cnt <= '0;
      bus.win         <= 1'b0;
    end else begin
      bus.done <= load;
      if (load) begin
        fb              <= fb_c;
        res_mode        <= mode_q;
        bus.exact_cnt   <= CW'($countones(ex));
        bus.partial_cnt <= CW'($countones(pa));
        bus.win         <= &ex;
      end
    end
  blink_timer #(.BLINK_DIV(BLINK_DIV)) u_blink (
    .clk         (clk),
    .reset       (reset),
    .enable      (bus.game_over),
    .blink_state (blink)
  );
  always_comb begin
    summ = '0;
    for (int i = 0; i < N_POS; i++) begin
      summ[i]         = CW'(i) < bus.partial_cnt;
      summ[N_POS + i] = CW'(i) < bus.exact_cnt;
    end
    bus.leds = bus.game_over ? {2*N_POS{blink}} : res_mode ? summ : fb;
  end
endmodule

// File: tb/tb_guess_scorer.sv
// tb_guess_scorer: directed vectors against a count-based scoring/timing model checked every cycle
module tb_guess_scorer;
  localparam int N = 4, W = 3, D = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0, n_fail = 0, lat, dcnt;
  always #5 clk = ~clk;
  guess_scorer_if #(.N_POS(N), .SYM_W(W)) bus();
  guess_scorer #(.N_POS(N), .SYM_W(W), .BLINK_DIV(D)) dut (.clk(clk), .reset(reset), .bus(bus));
  int             m_left = 0, m_go = 0;
  logic           m_done = 1'b0, m_mode = 1'b0, m_pmode = 1'b0, m_bph = 1'b0;
  logic [2*N-1:0] m_fb = '0, m_pfb = '0;
  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [N*W-1:0] pk(input int a, input int b, input int c, input int d);
    return {W'(a), W'(b), W'(c), W'(d)};
  endfunction
  // exact matches consume their secret symbol; leftover secret symbols feed partials, highest guess position first
  function automatic logic [2*N-1:0] model_fb(input logic [N*W-1:0] g, input logic [N*W-1:0] s);
    int             avail[1<<W];
    logic [2*N-1:0] r = '0;
    for (int v = 0; v < (1 << W); v++) avail[v] = 0;
    for (int i = 0; i < N; i++)
      if (g[i*W +: W] == s[i*W +: W]) r[2*i +: 2] = 2'b11;
      else avail[int'(s[i*W +: W])]++;
    for (int i = N - 1; i >= 0; i--)
      if (r[2*i +: 2] != 2'b11 && avail[int'(g[i*W +: W])] > 0) begin
        r[2*i +: 2] = 2'b01;
        avail[int'(g[i*W +: W])]--;
      end
    return r;
  endfunction
  function automatic int cnt(input logic [2*N-1:0] fb, input logic [1:0] code);
    int c = 0;
    for (int i = 0; i < N; i++) if (fb[2*i +: 2] == code) c++;
    return c;
  endfunction
  function automatic logic [2*N-1:0] exp_leds();
    logic [2*N-1:0] t = '0;
    if (bus.game_over) return ((((m_go / (D + 1)) % 2) == 0) == m_bph) ? '1 : '0;
    for (int i = 0; i < N; i++) begin
      t[i]     = i < cnt(m_fb, 2'b01);
      t[N + i] = i < cnt(m_fb, 2'b11);
    end
    return m_mode ? t : m_fb;
  endfunction
  always @(posedge clk or posedge reset)
    if (reset) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_fb   <= '0;
      m_mode <= 1'b0;
      m_go   <= 0;
      m_bph  <= 1'b0;
    end else begin
      m_go   <= bus.game_over ? m_go + 1 : 0;
      if (!bus.game_over) m_bph <= 1'b1;
      m_done <= m_left == 1;
      if (m_left == 1) begin
        m_fb   <= m_pfb;
        m_mode <= m_pmode;
      end
      if (m_left != 0) m_left <= m_left - 1;
      else if (bus.start) begin
        m_left  <= N + 2;
        m_pfb   <= model_fb(bus.guess_val, bus.secret_val);
        m_pmode <= bus.mode;
      end
    end
  always @(negedge clk) begin
    check("busy", int'(bus.busy), int'(m_left != 0));
    check("done", int'(bus.done), int'(m_done));
    check("exact_cnt", int'(bus.exact_cnt), cnt(m_fb, 2'b11));
    check("partial_cnt", int'(bus.partial_cnt), cnt(m_fb, 2'b01));
    check("win", int'(bus.win), int'(cnt(m_fb, 2'b11) == N));
    check("leds", int'(bus.leds), int'(exp_leds()));
  end
  task automatic go(input logic [N*W-1:0] g, input logic [N*W-1:0] s, input logic md);
    @(negedge clk);
    bus.guess_val = g; bus.secret_val = s; bus.mode = md; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.guess_val = ~g; bus.secret_val = g; bus.mode = ~md;
  endtask
  task automatic wait_done(output int l);
    l = 0;
    while (!bus.done && l < 20) begin
      @(posedge clk);
      #1 l++;
    end
  endtask
  task automatic run(input logic [N*W-1:0] g, input logic [N*W-1:0] s, input logic md);
    int l;
    go(g, s, md);
    wait_done(l);
    check("latency", l, N + 2);
  endtask
  task automatic res(input string nm, input int leds, input int ex, input int pa);
    check({nm, "_leds"}, int'(bus.leds), leds);
    check({nm, "_exact"}, int'(bus.exact_cnt), ex);
    check({nm, "_partial"}, int'(bus.partial_cnt), pa);
  endtask
  initial begin
    bus.start = 1'b0; bus.guess_val = '0; bus.secret_val = '0; bus.mode = 1'b0; bus.game_over = 1'b0;
    repeat (2) @(posedge clk);
    #1 res("reset", 0, 0, 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    @(negedge clk) reset = 1'b0;
    run(pk(5,3,2,1), pk(5,3,2,1), 1'b0); res("all_exact", 'hFF, 4, 0);
    check("all_exact_win", int'(bus.win), 1);
    run(pk(1,1,1,1), pk(1,2,3,4), 1'b0); res("dup_guess", 'hC0, 1, 0);
    check("dup_guess_win", int'(bus.win), 0);
    run(pk(1,1,1,1), pk(1,2,3,4), 1'b1); res("dup_guess_sum", 'h10, 1, 0);
    run(pk(2,2,1,1), pk(1,1,2,2), 1'b0); res("swap", 'h55, 0, 4);
    run(pk(2,2,1,1), pk(1,1,2,2), 1'b1); res("swap_sum", 'h0F, 0, 4);
    run(pk(3,0,0,7), pk(0,3,6,6), 1'b0); res("mixed", 'h50, 0, 2);
    // a second start while busy must neither restart nor rescore
    go(pk(1,1,1,1), pk(1,2,3,4), 1'b0);
    @(negedge clk);
    bus.guess_val = pk(5,3,2,1); bus.secret_val = pk(5,3,2,1); bus.mode = 1'b1; bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    wait_done(lat);
    check("busy_start_latency", lat, N + 1);
    res("busy_start", 'hC0, 1, 0);
    dcnt = 0;
    repeat (8) begin @(posedge clk); #1 if (bus.done) dcnt++; end
    check("busy_start_no_second_done", dcnt, 0);
    // start and game_over rise together; scoring proceeds under the blink
    @(negedge clk);
    bus.guess_val = pk(3,0,0,7); bus.secret_val = pk(0,3,6,6); bus.mode = 1'b1;
    bus.start = 1'b1; bus.game_over = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1 check("blink", int'(bus.leds), ((k / 5) % 2) == 0 ? 'hFF : 'h00);
      @(negedge clk) bus.start = 1'b0;
    end
    bus.game_over = 1'b0;
    #1 res("after_game_over", 'h03, 0, 2);
    go(pk(2,2,1,1), pk(1,1,2,2), 1'b0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1 check("abort_busy", int'(bus.busy), 0);
    check("abort_leds", int'(bus.leds), 0);
    @(negedge clk) reset = 1'b0;
    dcnt = 0;
    repeat (10) begin @(posedge clk); #1 if (bus.done) dcnt++; end
    check("abort_no_done", dcnt, 0);
    run(pk(5,3,2,1), pk(5,3,2,1), 1'b0); res("post_abort", 'hFF, 4, 0);
    check("post_abort_win", int'(bus.win), 1);
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1);
  end
endmodule

// File: doc/guess_scorer.md
GUESS_SCORER -- requirements
Module: guess_scorer

Interface
REQ-001 SHALL have parameter N_POS, default 4: number of code positions, at least 2.
REQ-002 SHALL have parameter SYM_W, default 3: bits per symbol.
REQ-003 SHALL have parameter BLINK_DIV, default 4: blink half-period is BLINK_DIV+1 clk cycles; BLINK_DIV is at least 1.
REQ-004 SHALL have port clk, input, 1: sole clock; all state changes on the rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: request to score the current operands; sampled only in IDLE.
REQ-007 SHALL have port guess_val, input, N_POS*SYM_W: position i occupies bits [i*SYM_W +: SYM_W].
REQ-008 SHALL have port secret_val, input, N_POS*SYM_W: same packing as guess_val.
REQ-009 SHALL have port mode, input, 1: 0 = positional display, 1 = summary display; sampled at start.
REQ-010 SHALL have port game_over, input, 1: high forces blink display.
REQ-011 SHALL have port leds, output, 2*N_POS: display.
REQ-012 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when the result registers update.
REQ-014 SHALL have ports exact_cnt and partial_cnt, output, clog2(N_POS+1) each: registered counts.
REQ-015 SHALL have port win, output, 1: registered; high when exact_cnt equals N_POS.

Function
REQ-016 SHALL capture guess_val, secret_val and mode when start is high in IDLE, then enter EXACT.
REQ-017 SHALL ignore start while busy; later input changes SHALL NOT affect the scoring in progress.
REQ-018 In EXACT (1 cycle), each position SHALL be marked exact when guess and secret symbols match; those secret positions are marked used.
REQ-019 In PARTIAL (N_POS cycles), SHALL scan one guess position per cycle from N_POS-1 down to 0.
REQ-020 During the PARTIAL scan, each non-exact guess position SHALL be marked partial when some unused secret position holds an equal symbol; the highest such index is marked used.
REQ-021 Each secret position SHALL count toward at most one exact or partial result, so duplicate symbols are never double counted.
REQ-022 In DONE (1 cycle), SHALL load the result registers, counts and win, pulse done, then return to IDLE.
REQ-023 Latency from the start-sampling edge to done high SHALL be N_POS+2 cycles; a new start is accepted in the cycle after done.
REQ-024 Positional display: pair [2i+1:2i] SHALL be 11 for exact, 01 for partial and 00 for none.
REQ-025 Summary display: upper N_POS bits SHALL hold an exact_cnt thermometer from the LSB upward; lower N_POS bits SHALL hold a partial_cnt thermometer.
REQ-026 With game_over high, leds SHALL be all-ones when blink_state=1 and all-zeros otherwise.
REQ-027 With game_over high, blink_state SHALL toggle and the timer SHALL clear when the timer reaches BLINK_DIV; otherwise the timer increments.
REQ-028 With game_over low, the timer SHALL be held at 0 and blink_state at 1, so blink always starts on the all-ones phase.
REQ-029 Scoring SHALL continue during game_over; results become visible once game_over drops.
REQ-030 If start and game_over rise in the same cycle, both SHALL be honoured independently.

Reset
REQ-031 Reset SHALL force: state IDLE, leds 0, busy 0, done 0, exact_cnt 0, partial_cnt 0, win 0, timer 0, blink_state 0, all results cleared.
REQ-032 Reset asserted mid-scan SHALL abort the scan with no done pulse; the first start after release SHALL score normally.

Structure
REQ-033 Package mastermind_pkg SHALL hold the state enum (IDLE, EXACT, PARTIAL, DONE) and the feedback codes FB_NONE=00, FB_PARTIAL=01, FB_EXACT=11.
REQ-034 The blink timer SHALL be the sub-module blink_timer (inputs clk, reset, enable; output blink_state; parameter BLINK_DIV).

Verification (N_POS=4, SYM_W=3, BLINK_DIV=4; symbols listed as pos3..pos0)
REQ-035 Guess 5,3,2,1 and secret 5,3,2,1, mode 0 -> done 6 cycles after start, leds 0xFF, exact 4, win 1.
REQ-036 Guess 1,1,1,1 and secret 1,2,3,4 -> leds 0xC0, exact 1, partial 0; with mode 1 -> leds 0x10.
REQ-037 Guess 2,2,1,1 and secret 1,1,2,2 -> leds 0x55, partial 4; with mode 1 -> leds 0x0F.
REQ-038 Guess 3,0,0,7 and secret 0,3,6,6 -> leds 0x50, exact 0, partial 2.
REQ-039 game_over held high -> leds 0xFF for 5 cycles, then 0x00 for 5 cycles, repeating; game_over low -> last result shown.
REQ-040 Reset pulsed on the 2nd PARTIAL cycle -> busy 0 and leds 0 immediately, no done; start pulsed during busy -> ignored.
